// File: rtl/mux8to1_rr.sv
// Eight-channel round-robin stream merger: one registered output word per cycle,
// tagged with the 3-bit index of the channel it came from.
module mux8to1_rr #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         in_valid,
  input  logic [8*WIDTH-1:0] in_data,
  output logic [7:0]         in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [2:0]         out_sel,
  input  logic               out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [2:0]       out_sel_q, out_sel_d;
  logic [2:0]       ptr_q, ptr_d;

  logic             load;
  logic             any_valid;
  logic [2:0]       grant;
  logic [WIDTH-1:0] ch_data [8];

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_chan
      assign ch_data[gi]  = in_data[gi*WIDTH +: WIDTH];
      // rst_n gating keeps every channel blocked while reset is held.
      assign in_ready[gi] = rst_n && load && any_valid && (grant == 3'(gi));
    end
  endgenerate

  assign any_valid = |in_valid;
  assign load      = !out_valid_q || out_ready;

  // Search starts one past the last grant; k = 8 wraps back to ptr itself.
  always_comb begin
    logic       found;
    logic [2:0] idx;
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= 8; k++) begin
      idx = ptr_q + 3'(k);
      if (!found && in_valid[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (load) begin
      if (any_valid) begin
        out_valid_d = 1'b1;
        out_data_d  = ch_data[grant];
        out_sel_d   = grant;
        ptr_d       = grant;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= 3'b000;
      ptr_q       <= 3'b111;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux8to1_rr.sv
// Bench for mux8to1_rr: directed scenarios plus random traffic, all checked
// through a scoreboard fed by an arbitration reference model.
`timescale 1ns/1ps
module tb_mux8to1_rr;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [7:0]     in_valid;
  logic [8*W-1:0] in_data;
  logic [7:0]     in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [2:0]     out_sel;
  logic           out_ready;

  mux8to1_rr #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
    .out_ready(out_ready)
  );

  always #10 clk = ~clk;

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [W+2:0] sb [$];
  logic [W-1:0] chan_data [8];
  int           m_ptr  = 7;
  bit           m_full = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs, predict grant from the round-robin rule, record result.
  task automatic step(input logic [7:0] v, input logic ordy, output int g);
    bit load;
    logic [7:0] exp_rdy;
    @(negedge clk);
    in_valid  = v;
    out_ready = ordy;
    for (int i = 0; i < 8; i++) in_data[i*W +: W] = chan_data[i];
    #1;
    load = !m_full || ordy;
    g = -1;
    if (load)
      for (int k = 1; k <= 8 && g < 0; k++)
        if (v[(m_ptr + k) % 8]) g = (m_ptr + k) % 8;
    exp_rdy = (g >= 0) ? (8'b1 << g) : 8'h00;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    if (load) begin
      if (g >= 0) begin
        sb.push_back({3'(g), chan_data[g]});
        m_ptr  = g;
        m_full = 1'b1;
      end else begin
        m_full = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    in_valid = 8'hFF;
    out_ready = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data",  32'(out_data), 0);
    chk("rst_out_sel",   32'(out_sel), 0);
    chk("rst_in_ready",  32'(in_ready), 0);
    sb.delete();
    m_full = 1'b0;
    m_ptr  = 7;
    in_valid = 8'h00;
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: every word leaving the output register must match the scoreboard head.
  initial begin
    logic [W+2:0] exp;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        chk("out_valid_vs_sb", 32'(out_valid), 32'(sb.size() != 0));
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_word: got sel %0d data %0h, expected none", out_sel, out_data);
          end else begin
            exp = sb.pop_front();
            chk("out_sel",  32'(out_sel),  32'(exp[W+2:W]));
            chk("out_data", 32'(out_data), 32'(exp[W-1:0]));
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "timeout");
  end

  initial begin
    int g;
    logic [7:0] rv;
    bit ordy;
    rst_n = 1'b0;
    in_valid = 8'hFF;
    out_ready = 1'b1;
    in_data = '0;
    for (int i = 0; i < 8; i++) chan_data[i] = 8'(8'h10 + i);
    repeat (2) @(negedge clk);
    #1;
    chk("init_in_ready", 32'(in_ready), 0);
    chk("init_out_valid", 32'(out_valid), 0);
    do_reset();

    // First word after reset goes to channel 0.
    chan_data[0] = 8'hA5;
    step(8'h01, 1'b1, g);
    #1;
    chk("t1_valid", 32'(out_valid), 1);
    chk("t1_data",  32'(out_data), 32'h A5);
    chk("t1_sel",   32'(out_sel), 0);
    chan_data[0] = 8'h10;
    do_reset();

    // Full-rate fair rotation.
    for (int k = 0; k < 10; k++) begin
      step(8'hFF, 1'b1, g);
      #1;
      chk("rr_sel",  32'(out_sel), 32'(k % 8));
      chk("rr_data", 32'(out_data), 32'(8'h10 + k % 8));
    end

    // Stall holds the word and blocks inputs.
    for (int k = 0; k < 3; k++) begin
      step(8'h24, 1'b0, g);
      #1;
      chk("stall_valid", 32'(out_valid), 1);
      chk("stall_sel",   32'(out_sel), 1);
      chk("stall_data",  32'(out_data), 32'h11);
    end
    step(8'h24, 1'b1, g);
    #1;
    chk("release_sel2", 32'(out_sel), 2);
    step(8'h20, 1'b1, g);
    #1;
    chk("release_sel5", 32'(out_sel), 5);

    // Wrap past channel 7 and skip idle channels.
    step(8'h40, 1'b1, g);
    #1;
    chk("wrap_sel6", 32'(out_sel), 6);
    step(8'h03, 1'b1, g);
    #1;
    chk("wrap_sel0", 32'(out_sel), 0);
    step(8'h02, 1'b1, g);
    #1;
    chk("wrap_sel1", 32'(out_sel), 1);

    // Drain: valid falls, data holds.
    step(8'h00, 1'b1, g);
    #1;
    chk("drain_valid", 32'(out_valid), 0);
    chk("drain_data",  32'(out_data), 32'h11);
    chk("drain_sel",   32'(out_sel), 1);

    // Mid-stream reset, then lowest valid channel wins.
    for (int k = 0; k < 4; k++) step(8'hFF, 1'b1, g);
    do_reset();
    step(8'h18, 1'b1, g);
    #1;
    chk("post_rst_sel",  32'(out_sel), 3);
    chk("post_rst_data", 32'(out_data), 32'h13);

    // Random traffic obeying the hold-until-ready rule.
    rv = 8'h00;
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < 8; i++) begin
        if (!rv[i] && ($urandom_range(3, 0) < ((n < 1000) ? 1 : 3))) begin
          rv[i] = 1'b1;
          chan_data[i] = 8'($urandom);
        end
      end
      ordy = ($urandom_range(3, 0) != 0);
      step(rv, ordy, g);
      if (g >= 0) rv[g] = 1'b0;
    end

    for (int i = 0; i < 20 && sb.size() > 0; i++) step(8'h00, 1'b1, g);
    @(negedge clk);
    #3;
    chk("final_sb_empty", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
